// File: rtl/dkong_dl_pkg.sv
// ----------------------------------------------------------------------------
// dkong_dl_pkg
//   Shared definitions for the ROM download loader and its consumers:
//     - dl_state_t   : loader FSM state encoding
//     - DL_RGN_OBJx  : upper address nibble of the four OBJ ROM regions
//                      (0xA000-0xDFFF on the download bus)
//     - DL_GAP_MIN/MAX : legal range of the post-write idle gap
// ----------------------------------------------------------------------------
package dkong_dl_pkg;

    typedef enum logic [2:0] {
        DL_IDLE  = 3'd0,
        DL_WAIT  = 3'd1,
        DL_WRITE = 3'd2,
        DL_GAP   = 3'd3,
        DL_DONE  = 3'd4
    } dl_state_t;

    localparam logic [3:0] DL_RGN_OBJ1 = 4'hA;
    localparam logic [3:0] DL_RGN_OBJ2 = 4'hB;
    localparam logic [3:0] DL_RGN_OBJ3 = 4'hC;
    localparam logic [3:0] DL_RGN_OBJ4 = 4'hD;

    localparam int DL_GAP_MIN = 0;
    localparam int DL_GAP_MAX = 15;

endpackage

// File: rtl/dkong_dl_loader.sv
// ----------------------------------------------------------------------------
// dkong_dl_loader
//   Producer end of the ROM download bus. Takes a byte stream from the host
//   over a valid/ready handshake and emits one paced DL_WR pulse per byte at
//   consecutive addresses starting from I_BASE. O_BUSY holds the core in
//   reset while loading; O_DONE and O_CSUM report the result.
//
// Parameters
//   GAP_CYCLES : DL_WR-low cycles after each write pulse (0..15, clamped)
//   ADDR_W     : download address width
//
// Ports
//   CLK_24M    in  system clock
//   I_RSTn     in  asynchronous active-low reset
//   I_START    in  1-cycle start pulse (ignored while a load is running)
//   I_BASE     in  first download address, sampled on an accepted start
//   I_LEN      in  byte count 0..2^ADDR_W, sampled on an accepted start
//   I_S_DATA   in  stream byte
//   I_S_VALID  in  stream byte valid
//   O_S_READY  out loader takes a byte this cycle (pure state decode)
//   DL_ADDR    out download address
//   DL_DATA    out download data
//   DL_WR      out write strobe, one cycle per byte
//   O_BUSY     out load in progress
//   O_DONE     out last load completed, held until the next accepted start
//   O_CSUM     out mod-256 sum of bytes written in the current/last load
// ----------------------------------------------------------------------------
module dkong_dl_loader
    import dkong_dl_pkg::*;
#(
    parameter int GAP_CYCLES = 1,
    parameter int ADDR_W     = 16
) (
    input  logic              CLK_24M,
    input  logic              I_RSTn,
    input  logic              I_START,
    input  logic [ADDR_W-1:0] I_BASE,
    input  logic [ADDR_W:0]   I_LEN,
    input  logic [7:0]        I_S_DATA,
    input  logic              I_S_VALID,
    output logic              O_S_READY,
    output logic [ADDR_W-1:0] DL_ADDR,
    output logic [7:0]        DL_DATA,
    output logic              DL_WR,
    output logic              O_BUSY,
    output logic              O_DONE,
    output logic [7:0]        O_CSUM
);

    // Out-of-range gap settings are clamped rather than rejected.
    localparam int GAP_EFF = (GAP_CYCLES > DL_GAP_MAX) ? DL_GAP_MAX :
                             (GAP_CYCLES < DL_GAP_MIN) ? DL_GAP_MIN : GAP_CYCLES;
    // Gap timer counts down to zero, so it is loaded with GAP-1.
    localparam logic [3:0] GAP_LOAD = (GAP_EFF == 0) ? 4'd0 : 4'(GAP_EFF - 1);

    dl_state_t         state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   count_q;
    logic [3:0]        gap_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              wr_q;
    logic              busy_q;
    logic              done_q;
    logic [7:0]        csum_q;

    logic [ADDR_W:0]   count_inc;

    assign count_inc = count_q + 1'b1;

    always_ff @(posedge CLK_24M or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q <= DL_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            gap_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            csum_q  <= '0;
        end else begin
            // Strobe is only ever set on the WAIT->WRITE transition.
            wr_q <= 1'b0;
            case (state_q)
                DL_IDLE, DL_DONE: begin
                    if (I_START) begin
                        base_q  <= I_BASE;
                        len_q   <= I_LEN;
                        count_q <= '0;
                        csum_q  <= '0;
                        busy_q  <= 1'b1;
                        if (I_LEN == '0) begin
                            // Zero-length load: done immediately, busy for
                            // exactly this one cycle (cleared in DONE below).
                            state_q <= DL_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DL_WAIT;
                            done_q  <= 1'b0;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end

                DL_WAIT: begin
                    // O_S_READY is exactly (state_q == DL_WAIT).
                    if (I_S_VALID) begin
                        addr_q  <= base_q + count_q[ADDR_W-1:0];
                        data_q  <= I_S_DATA;
                        wr_q    <= 1'b1;
                        state_q <= DL_WRITE;
                    end
                end

                DL_WRITE: begin
                    csum_q  <= csum_q + data_q;
                    count_q <= count_inc;
                    if (GAP_EFF != 0) begin
                        gap_q   <= GAP_LOAD;
                        state_q <= DL_GAP;
                    end else if (count_inc == len_q) begin
                        state_q <= DL_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DL_WAIT;
                    end
                end

                DL_GAP: begin
                    if (gap_q != 4'd0) begin
                        gap_q <= gap_q - 4'd1;
                    end else if (count_q == len_q) begin
                        state_q <= DL_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DL_WAIT;
                    end
                end

                default: begin
                    state_q <= DL_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign O_S_READY = (state_q == DL_WAIT);
    assign DL_ADDR   = addr_q;
    assign DL_DATA   = data_q;
    assign DL_WR     = wr_q;
    assign O_BUSY    = busy_q;
    assign O_DONE    = done_q;
    assign O_CSUM    = csum_q;

endmodule

// File: tb/tb_dkong_dl_loader.sv
// ----------------------------------------------------------------------------
// tb_dkong_dl_loader
//   Directed bench for dkong_dl_loader with GAP_CYCLES=1. A negedge monitor
//   logs every DL_WR pulse (address, data, cycle); each test then compares the
//   log and the status outputs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_dkong_dl_loader;
    import dkong_dl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base;
    logic [16:0] len;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wr;
    logic        busy;
    logic        done;
    logic [7:0]  csum;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] wr_addr [$];
    logic [7:0]  wr_data [$];
    int          wr_cyc  [$];
    logic [7:0]  src     [$];

    dkong_dl_loader #(.GAP_CYCLES(1), .ADDR_W(16)) dut (
        .CLK_24M  (clk),
        .I_RSTn   (rst_n),
        .I_START  (start),
        .I_BASE   (base),
        .I_LEN    (len),
        .I_S_DATA (s_data),
        .I_S_VALID(s_valid),
        .O_S_READY(s_ready),
        .DL_ADDR  (dl_addr),
        .DL_DATA  (dl_data),
        .DL_WR    (dl_wr),
        .O_BUSY   (busy),
        .O_DONE   (done),
        .O_CSUM   (csum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dl_wr === 1'b1) begin
            wr_addr.push_back(dl_addr);
            wr_data.push_back(dl_data);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    task automatic do_start(input logic [15:0] b, input logic [16:0] l);
        base  = b;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drive src[] as a stream. rand_valid toggles valid pseudo-randomly and
    // puts junk on the data bus whenever valid is low. restart_at pulses a
    // conflicting I_START once; stop_at ends early after that many accepts.
    task automatic feed(input bit rand_valid, input int restart_at, input int stop_at,
                        input string tag);
        int  idx      = 0;
        int  budget   = 400;
        int  target   = (stop_at >= 0) ? stop_at : src.size();
        bit  restarted = 1'b0;
        bit  v;
        bit  rdy;
        while (idx < target && budget > 0) begin
            v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid = v;
            s_data  = v ? src[idx] : 8'($urandom);
            if (idx == restart_at && !restarted) begin
                start     = 1'b1;
                base      = 16'h5000;
                len       = 17'd1;
                restarted = 1'b1;
            end
            rdy = s_ready;
            tick();
            start = 1'b0;
            if (v && rdy) idx++;
            budget--;
        end
        s_valid = 1'b0;
        chk({tag, "_accepted"}, idx, target);
    endtask

    task automatic wait_done(input string tag);
        int budget = 60;
        while (done !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic check_writes(input logic [15:0] b, input string tag);
        logic [15:0] a;
        chk({tag, "_nwrites"}, wr_addr.size(), src.size());
        for (int i = 0; i < src.size() && i < wr_addr.size(); i++) begin
            a = b + 16'(i);
            chk($sformatf("%s_addr%0d", tag, i), wr_addr[i], a);
            chk($sformatf("%s_data%0d", tag, i), wr_data[i], src[i]);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        base    = '0;
        len     = '0;
        s_data  = '0;
        s_valid = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_dl_wr", dl_wr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_csum", csum, 8'h00);
        chk("rst_addr", dl_addr, 16'h0000);
        chk("rst_ready", s_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        $display("reset check done, failures so far %0d", n_fail);

        // T1: OBJ1 region, 4 bytes back to back
        clear_log();
        src = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_start({DL_RGN_OBJ1, 12'h000}, 17'd4);
        chk("t1_busy", busy, 1'b1);
        chk("t1_ready", s_ready, 1'b1);
        feed(1'b0, -1, -1, "t1");
        wait_done("t1");
        check_writes(16'hA000, "t1");
        for (int i = 1; i < wr_cyc.size(); i++)
            chk($sformatf("t1_spacing%0d", i), wr_cyc[i] - wr_cyc[i-1], 3);
        if (wr_cyc.size() == 4)
            chk("t1_done_latency", cyc - wr_cyc[3], 2);
        chk("t1_csum", csum, 8'hAA);
        $display("T1 base=A000 len=4 writes=%0d csum=%0h", wr_addr.size(), csum);

        // T2: zero-length load
        clear_log();
        do_start(16'h1234, 17'd0);
        chk("t2_done", done, 1'b1);
        chk("t2_busy_pulse", busy, 1'b1);
        chk("t2_csum", csum, 8'h00);
        tick();
        chk("t2_busy_low", busy, 1'b0);
        chk("t2_done_held", done, 1'b1);
        tick();
        chk("t2_nwrites", wr_addr.size(), 0);
        $display("T2 len=0 done=%0b writes=%0d", done, wr_addr.size());

        // T3: random valid, junk data while not valid
        clear_log();
        src = '{8'h5A, 8'hA5, 8'h01, 8'hFF, 8'h80, 8'h7F};
        do_start(16'h0100, 17'd6);
        chk("t3_done_cleared", done, 1'b0);
        feed(1'b1, -1, -1, "t3");
        wait_done("t3");
        check_writes(16'h0100, "t3");
        chk("t3_csum", csum, 8'hFE);
        $display("T3 base=0100 len=6 writes=%0d csum=%0h", wr_addr.size(), csum);

        // T4: address wrap
        clear_log();
        src = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_start(16'hFFFE, 17'd4);
        feed(1'b0, -1, -1, "t4");
        wait_done("t4");
        check_writes(16'hFFFE, "t4");
        chk("t4_csum", csum, 8'h0A);
        $display("T4 base=FFFE len=4 writes=%0d csum=%0h", wr_addr.size(), csum);

        // T5: restart attempt mid-load is ignored
        clear_log();
        src = '{8'h10, 8'h20, 8'h30};
        do_start(16'h2000, 17'd3);
        feed(1'b0, 1, -1, "t5");
        wait_done("t5");
        check_writes(16'h2000, "t5");
        chk("t5_csum", csum, 8'h60);
        $display("T5 base=2000 len=3 writes=%0d csum=%0h", wr_addr.size(), csum);

        // T6: reset after 2 of 8 bytes accepted
        clear_log();
        src = '{8'h81, 8'h42, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_start(16'h3000, 17'd8);
        feed(1'b0, -1, 2, "t6");
        chk("t6_wr_before_rst", dl_wr, 1'b1);
        chk("t6_csum_before_rst", csum, 8'h81);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dl_wr", dl_wr, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        chk("t6_rst_csum", csum, 8'h00);
        chk("t6_rst_addr", dl_addr, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_idle_done", done, 1'b0);
        clear_log();
        src = '{8'hC3, 8'h3C};
        do_start(16'h4000, 17'd2);
        feed(1'b0, -1, -1, "t6b");
        wait_done("t6b");
        check_writes(16'h4000, "t6b");
        chk("t6b_csum", csum, 8'hFF);
        $display("T6 reload base=4000 len=2 writes=%0d csum=%0h", wr_addr.size(), csum);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
